// File: rtl/nibble_add_scheduler.sv
// rtl/nibble_add_scheduler.sv - round-robin scheduler sharing one external 4-bit adder between two requesters
// Operands are added one nibble per cycle, LSB first; the result becomes visible only on completion.
module nibble_add_scheduler #(
  parameter int NIB = 4,
  localparam int W = 4 * NIB
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         cin0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic         cin1,
  output logic [1:0]   gnt,
  output logic         busy,
  output logic         done,
  output logic         done_id,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic [3:0]   add_a,
  output logic [3:0]   add_b,
  output logic         add_cin,
  input  logic [3:0]   add_sum,
  input  logic         add_cout
);

  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  a_q, b_q, res, res_next;
  logic [IW-1:0] idx;
  logic          carry;
  logic          served;
  logic          last;
  logic          win;
  logic          last_nib;

  // On a tie the requester that was not served last wins; reset leaves last=1 so requester 0 wins first.
  assign win      = (req0 && req1) ? ~last : req1;
  assign last_nib = (idx == IW'(NIB - 1));

  always_comb begin
    res_next = res;
    res_next[idx*4 +: 4] = add_sum;
  end

  always_comb begin
    add_a   = 4'd0;
    add_b   = 4'd0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_q[idx*4 +: 4];
      add_b   = b_q[idx*4 +: 4];
      add_cin = carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res     <= '0;
      idx     <= '0;
      carry   <= 1'b0;
      served  <= 1'b0;
      last    <= 1'b1;
      gnt     <= 2'b00;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      sum     <= '0;
      c_out   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (req0 || req1) begin
            served <= win;
            a_q    <= win ? a1 : a0;
            b_q    <= win ? b1 : b0;
            carry  <= win ? cin1 : cin0;
            idx    <= '0;
            res    <= '0;
            gnt    <= win ? 2'b10 : 2'b01;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          res   <= res_next;
          carry <= add_cout;
          idx   <= idx + 1'b1;
          if (last_nib) begin
            // Final carry goes only to c_out; the next operation reloads carry from its own cin.
            idx     <= '0;
            sum     <= res_next;
            c_out   <= add_cout;
            done_id <= served;
            last    <= served;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          gnt   <= 2'b00;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_add_scheduler.sv
// tb/tb_nibble_add_scheduler.sv - directed self-checking bench for nibble_add_scheduler
// Models the external 4-bit adder and checks timing, arbitration and results against hand values.
module tb_nibble_add_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        cin0 = 1'b0, cin1 = 1'b0;
  logic [1:0]  gnt;
  logic        busy, done, done_id, c_out;
  logic [15:0] sum;
  logic [3:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;

  int checks = 0;
  int errors = 0;

  logic [1:0]  gnt_log [1:8];
  logic        cin_log [1:8];
  logic        busy_log[1:8];
  int          done_at;
  logic [15:0] obs_sum, sum_mid;
  logic        obs_cout, obs_id;
  logic        idle_busy, idle_done;
  logic [1:0]  idle_gnt;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = add_a + add_b + add_cin;

  nibble_add_scheduler #(.NIB(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .cin0(cin0),
    .req1(req1), .a1(a1), .b1(b1), .cin1(cin1),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
    .sum(sum), .c_out(c_out),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  // Stimulus/observation only: called at a falling edge while the DUT is IDLE, returns at a falling edge in IDLE.
  task automatic do_op(input bit id, input logic [15:0] a, input logic [15:0] b, input logic cin, input bit drop_early);
    if (id) begin req1 = 1'b1; a1 = a; b1 = b; cin1 = cin; end
    else    begin req0 = 1'b1; a0 = a; b0 = b; cin0 = cin; end
    done_at = 0;
    sum_mid = sum;
    @(posedge clk);
    for (int c = 1; c <= 8 && done_at == 0; c++) begin
      @(negedge clk);
      gnt_log[c]  = gnt;
      cin_log[c]  = add_cin;
      busy_log[c] = busy;
      if (c == 2) sum_mid = sum;
      if (drop_early && c == 1) begin req0 = 1'b0; req1 = 1'b0; end
      if (done) begin
        done_at  = c;
        obs_sum  = sum;
        obs_cout = c_out;
        obs_id   = done_id;
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    idle_busy = busy;
    idle_gnt  = gnt;
    idle_done = done;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req0 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b exp 00", gnt); end
    checks++; if ({busy, done, done_id, c_out} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {busy, done, done_id, c_out}); end
    checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum got %h exp 0000", sum); end
    checks++; if ({add_a, add_b, add_cin} !== 9'd0) begin errors++; $display("FAIL reset_adder got %h exp 000", {add_a, add_b, add_cin}); end
    rst = 1'b0;
    req0 = 1'b0;
  endtask

  task automatic test_basic;
    do_op(1'b0, 16'h1234, 16'h4321, 1'b0, 1'b0);
    checks++; if (done_at !== 5) begin errors++; $display("FAIL basic_latency got %0d exp 5", done_at); end
    for (int c = 1; c <= 5; c++) begin
      checks++; if ({gnt_log[c], busy_log[c]} !== 3'b011) begin errors++; $display("FAIL basic_gnt_busy cycle %0d got %b exp 011", c, {gnt_log[c], busy_log[c]}); end
    end
    checks++; if (obs_sum !== 16'h5555) begin errors++; $display("FAIL basic_sum got %h exp 5555", obs_sum); end
    checks++; if ({obs_cout, obs_id} !== 2'b00) begin errors++; $display("FAIL basic_cout_id got %b exp 00", {obs_cout, obs_id}); end
    checks++; if ({idle_gnt, idle_busy, idle_done} !== 4'b0000) begin errors++; $display("FAIL basic_idle got %b exp 0000", {idle_gnt, idle_busy, idle_done}); end
    checks++; if (sum !== 16'h5555) begin errors++; $display("FAIL basic_hold got %h exp 5555", sum); end
  endtask

  task automatic test_carry_chain;
    do_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    checks++; if (done_at !== 5) begin errors++; $display("FAIL chain_latency got %0d exp 5", done_at); end
    checks++; if (gnt_log[1] !== 2'b10) begin errors++; $display("FAIL chain_gnt got %b exp 10", gnt_log[1]); end
    checks++; if ({cin_log[1], cin_log[2], cin_log[3], cin_log[4]} !== 4'b0111) begin errors++; $display("FAIL chain_add_cin got %b exp 0111", {cin_log[1], cin_log[2], cin_log[3], cin_log[4]}); end
    checks++; if (cin_log[5] !== 1'b0) begin errors++; $display("FAIL chain_done_cin got %b exp 0", cin_log[5]); end
    checks++; if (sum_mid !== 16'h5555) begin errors++; $display("FAIL chain_no_partial got %h exp 5555", sum_mid); end
    checks++; if (obs_sum !== 16'h0000) begin errors++; $display("FAIL chain_sum got %h exp 0000", obs_sum); end
    checks++; if ({obs_cout, obs_id} !== 2'b11) begin errors++; $display("FAIL chain_cout_id got %b exp 11", {obs_cout, obs_id}); end
  endtask

  task automatic test_cin;
    do_op(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    checks++; if ({obs_cout, obs_sum} !== 17'h00001) begin errors++; $display("FAIL cin_zero got %h exp 00001", {obs_cout, obs_sum}); end
    do_op(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    checks++; if ({obs_cout, obs_sum} !== 17'h1FFFF) begin errors++; $display("FAIL cin_max got %h exp 1ffff", {obs_cout, obs_sum}); end
    checks++; if (obs_id !== 1'b1) begin errors++; $display("FAIL cin_max_id got %b exp 1", obs_id); end
  endtask

  task automatic test_drop_early;
    do_op(1'b0, 16'h0F0F, 16'h0101, 1'b0, 1'b1);
    checks++; if (done_at !== 5) begin errors++; $display("FAIL drop_latency got %0d exp 5", done_at); end
    checks++; if ({obs_cout, obs_sum} !== 17'h01010) begin errors++; $display("FAIL drop_sum got %h exp 01010", {obs_cout, obs_sum}); end
    checks++; if (idle_busy !== 1'b0) begin errors++; $display("FAIL drop_idle got %b exp 0", idle_busy); end
  endtask

  task automatic test_reset_mid;
    bit seen_done;
    req0 = 1'b1; a0 = 16'hABCD; b0 = 16'h1111; cin0 = 1'b0;
    @(posedge clk);
    repeat (3) @(negedge clk);
    checks++; if (add_a !== 4'hB) begin errors++; $display("FAIL mid_idx2 got %h exp b", add_a); end
    rst = 1'b1;
    req0 = 1'b0;
    @(negedge clk);
    checks++; if ({busy, gnt, done} !== 4'b0000) begin errors++; $display("FAIL mid_state got %b exp 0000", {busy, gnt, done}); end
    checks++; if ({c_out, sum} !== 17'h00000) begin errors++; $display("FAIL mid_result got %h exp 00000", {c_out, sum}); end
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL mid_no_done got %b exp 0", seen_done); end
  endtask

  task automatic test_back_to_back;
    logic        ids [4];
    logic [15:0] sums[4];
    int n = 0;
    int overlap = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req0 = 1'b1; a0 = 16'h0001; b0 = 16'h0002; cin0 = 1'b0;
    req1 = 1'b1; a1 = 16'h0010; b1 = 16'h0020; cin1 = 1'b1;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (gnt == 2'b11) overlap++;
      if (done) begin
        ids[n]  = done_id;
        sums[n] = sum;
        n++;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    checks++; if (n !== 4) begin errors++; $display("FAIL b2b_count got %0d exp 4", n); end
    checks++; if (overlap !== 0) begin errors++; $display("FAIL b2b_overlap got %0d exp 0", overlap); end
    for (int i = 0; i < n; i++) begin
      checks++; if (ids[i] !== 1'(i % 2)) begin errors++; $display("FAIL b2b_order op %0d got %b exp %0d", i, ids[i], i % 2); end
      checks++; if (sums[i] !== ((i % 2) ? 16'h0031 : 16'h0003)) begin errors++; $display("FAIL b2b_sum op %0d got %h exp %h", i, sums[i], (i % 2) ? 16'h0031 : 16'h0003); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_basic;
    test_carry_chain;
    test_cin;
    test_drop_early;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nibble_add_scheduler.md
NIBBLE_ADD_SCHEDULER -- requirements
Module: nibble_add_scheduler

Interface
REQ-001 Parameter NIB, default 4, number of 4-bit nibbles per operand; operand width W = 4*NIB.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0  input  1  requester 0 operation request.
REQ-005 a0, b0  input  W each  requester 0 operands.
REQ-006 cin0  input  1  requester 0 carry-in.
REQ-007 req1, a1, b1, cin1  input  1/W/W/1  requester 1 equivalents.
REQ-008 gnt  output  2  one-hot grant; bit0 = requester 0, bit1 = requester 1.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 done_id  output  1  index of the requester whose result is on sum/c_out.
REQ-012 sum  output  W  registered result; c_out  output  1  registered final carry.
REQ-013 add_a, add_b  output  4 each  nibble operands to the shared external 4-bit ripple adder.
REQ-014 add_cin  output  1  carry-in to the shared adder.
REQ-015 add_sum  input  4; add_cout  input  1  shared adder results, combinational in same cycle.

Function
REQ-016 FSM states: IDLE, RUN, DONE; no other states reachable.
REQ-017 IDLE: with any req high at a rising edge, capture winner's a, b, cin into internal registers, clear nibble index idx to 0, load carry register with cin, go RUN.
REQ-018 Arbitration: round-robin; single request wins; on simultaneous requests the requester not served last wins; after reset requester 0 wins ties.
REQ-019 gnt asserted one-hot from first RUN cycle through DONE inclusive; 2'b00 in IDLE.
REQ-020 RUN: add_a/add_b = captured nibble idx of a/b, add_cin = carry register.
REQ-021 RUN edge: write add_sum into result nibble idx, carry <= add_cout, idx <= idx+1; after nibble NIB-1 go DONE.
REQ-022 DONE: done=1 for exactly one cycle; sum = full result, c_out = final carry, done_id = served requester; next state IDLE; last-served pointer updated.
REQ-023 Latency: request sampled at edge k; RUN occupies cycles k+1..k+NIB; done high in cycle k+NIB+1; next grant possible at cycle k+NIB+3 at earliest.
REQ-024 sum, c_out, done_id hold their values until the next DONE or reset; not modified nibble-by-nibble visibly (update from a shadow register on DONE entry).
REQ-025 Requests and operand inputs ignored outside IDLE; a req deasserted mid-operation does not abort it.
REQ-026 Requester must drop req in the cycle after done; req still high in IDLE counts as a new request.
REQ-027 In IDLE and DONE, add_a, add_b, add_cin driven 0.
REQ-028 Carry wrap: carry out of nibble NIB-1 appears only on c_out; never fed back.

Reset
REQ-029 rst high at an edge forces IDLE, idx=0, carry=0, pointer favouring requester 0, regardless of state.
REQ-030 After reset: gnt=0, busy=0, done=0, done_id=0, sum=0, c_out=0, add_a=0, add_b=0, add_cin=0.
REQ-031 Reset during RUN or DONE aborts the operation; no done pulse for it.

Verification
REQ-032 NIB=4, req0, a0=16'h1234, b0=16'h4321, cin0=0 -> gnt=01 for 5 cycles, done in 5th cycle after sample, sum=16'h5555, c_out=0, done_id=0.
REQ-033 req1, a1=16'hFFFF, b1=16'h0001, cin1=0 -> sum=16'h0000, c_out=1, done_id=1; add_cin observed 0,1,1,1 across RUN cycles.
REQ-034 a0=b0=16'h0000, cin0=1 -> sum=16'h0001, c_out=0.
REQ-035 req0 and req1 high together from reset, each held until its done -> served order 0,1,0,1; done_id alternates; no overlap of gnt bits.
REQ-036 rst pulsed while idx=2 in RUN -> next cycle busy=0, gnt=0, sum=0, c_out=0; no done pulse.
REQ-037 req0 dropped after first RUN cycle -> operation completes, done pulse and correct sum still produced.
